trap_ctrl: RTL and testbench

Machine-mode trap controller that produces the exception redirect consumed by the next-PC logic.
- Inputs: execute-stage exception events and the external interrupt.
- State: mstatus, mie, mtvec, mepc and mcause CSRs.
- Outputs: a one-cycle `exce` pulse with `exce_pc` set to the trap vector (on trap) or mepc (on mret).
- The `exce`/`exce_pc` outputs connect directly to the next-PC block's exception inputs.

---
 rtl/trap_ctrl_if.sv | 32 +++
 rtl/trap_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_trap_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/trap_ctrl_if.sv
// Purpose: bundles the execute-stage event inputs, CSR access bus and redirect
//          outputs of the machine-mode trap controller into one port.
// Ports:   pc/illegal_instr/ebreak/ecall/mret/ext_irq (events), csr_we/csr_addr/
//          csr_wdata/csr_rdata (CSR access), exce/exce_pc/busy (redirect to next-PC).
//          master = pipeline side driving events, slave = trap_ctrl.
interface trap_ctrl_if;
   logic [31:0] pc;
   logic        illegal_instr;
   logic        ebreak;
   logic        ecall;
   logic        mret;
   logic        ext_irq;
   logic        csr_we;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata;
   logic        exce;
   logic [31:0] exce_pc;
   logic        busy;

   modport master (
      output pc, illegal_instr, ebreak, ecall, mret, ext_irq,
      output csr_we, csr_addr, csr_wdata,
      input  csr_rdata, exce, exce_pc, busy
   );

   modport slave (
      input  pc, illegal_instr, ebreak, ecall, mret, ext_irq,
      input  csr_we, csr_addr, csr_wdata,
      output csr_rdata, exce, exce_pc, busy
   );
endinterface

// File: rtl/trap_ctrl.sv
// Purpose: machine-mode trap controller (mstatus/mie/mtvec/mepc/mcause) that issues
//          a one-cycle exception redirect (exce/exce_pc) to the next-PC logic.
// Latency: event sampled in cycle N -> exce high in cycle N+1 only; busy for N+1, N+2.
// Backpressure: none accepted; while busy, events and CSR writes are dropped.
// Ports:   clk, rstn (async active-low), bus (trap_ctrl_if.slave): execute-stage
//          events, CSR read/write port (combinational read), redirect strobe/target.
// Option:  define VECTORED_MTVEC_EN to make mtvec bit0 a mode bit; in vectored mode
//          interrupts jump to base + 4*IRQ_CAUSE, exceptions always go to base.
module trap_ctrl #(
   parameter logic [31:0] RESET_MTVEC = 32'h0000_0100,
   parameter logic [31:0] IRQ_CAUSE   = 32'd11
) (
   input  logic        clk,
   input  logic        rstn,
   trap_ctrl_if.slave  bus
);

   localparam logic [11:0] ADDR_MSTATUS = 12'h300;
   localparam logic [11:0] ADDR_MIE     = 12'h304;
   localparam logic [11:0] ADDR_MTVEC   = 12'h305;
   localparam logic [11:0] ADDR_MEPC    = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

   localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
   localparam logic [31:0] CAUSE_EBREAK  = 32'd3;
   localparam logic [31:0] CAUSE_ECALL   = 32'd11;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_REDIRECT = 2'd1,
      ST_FLUSH    = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;

   // Architectural CSR state; only implemented bits are stored.
   logic        mstatus_mie;
   logic        mstatus_mpie;
   logic        mie_meie;
   logic [29:0] mtvec_base;
`ifdef VECTORED_MTVEC_EN
   logic        mtvec_mode;
`endif
   logic [31:0] mepc;
   logic [31:0] mcause;
   logic [31:0] exce_pc_q;

   // Per-cycle decisions from the next-state process.
   logic        irq_pending;
   logic        take_exc;
   logic        take_irq;
   logic        take_ret;
   logic        csr_wr_en;
   logic [31:0] exc_cause;
   logic [31:0] trap_cause;
   logic [31:0] trap_target;

   assign irq_pending = bus.ext_irq & mstatus_mie & mie_meie;

   // ------------------------------------------------------------------
   // Next-state / event arbitration. Only IDLE looks at events; a taken
   // trap or mret claims the cycle, so a coincident CSR write is dropped.
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      take_exc  = 1'b0;
      take_irq  = 1'b0;
      take_ret  = 1'b0;
      csr_wr_en = 1'b0;
      exc_cause = '0;
      case (state)
         ST_IDLE: begin
            if (bus.illegal_instr) begin
               take_exc  = 1'b1;
               exc_cause = CAUSE_ILLEGAL;
            end else if (bus.ebreak) begin
               take_exc  = 1'b1;
               exc_cause = CAUSE_EBREAK;
            end else if (bus.ecall) begin
               take_exc  = 1'b1;
               exc_cause = CAUSE_ECALL;
            end else if (bus.mret) begin
               take_ret  = 1'b1;
            end else if (irq_pending) begin
               take_irq  = 1'b1;
            end

            if (take_exc || take_irq || take_ret) begin
               state_nxt = ST_REDIRECT;
            end else begin
               csr_wr_en = bus.csr_we;
            end
         end
         ST_REDIRECT: state_nxt = ST_FLUSH;
         ST_FLUSH:    state_nxt = ST_IDLE;
         default:     state_nxt = ST_IDLE;
      endcase
   end

   // Trap cause and vector target.
   always_comb begin
      trap_cause  = take_irq ? {1'b1, IRQ_CAUSE[30:0]} : exc_cause;
      trap_target = {mtvec_base, 2'b00};
`ifdef VECTORED_MTVEC_EN
      if (take_irq && mtvec_mode) begin
         trap_target = {mtvec_base, 2'b00} + {IRQ_CAUSE[29:0], 2'b00};
      end
`endif
   end

   // ------------------------------------------------------------------
   // State register, CSRs and the redirect target.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state        <= ST_IDLE;
         mstatus_mie  <= 1'b0;
         mstatus_mpie <= 1'b0;
         mie_meie     <= 1'b0;
         mtvec_base   <= RESET_MTVEC[31:2];
`ifdef VECTORED_MTVEC_EN
         mtvec_mode   <= RESET_MTVEC[0];
`endif
         mepc         <= '0;
         mcause       <= '0;
         exce_pc_q    <= '0;
      end else begin
         state <= state_nxt;
         if (take_exc || take_irq) begin
            mepc         <= bus.pc;
            mcause       <= trap_cause;
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
            exce_pc_q    <= trap_target;
         end else if (take_ret) begin
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
            exce_pc_q    <= mepc;
         end else if (csr_wr_en) begin
            case (bus.csr_addr)
               ADDR_MSTATUS: begin
                  mstatus_mie  <= bus.csr_wdata[3];
                  mstatus_mpie <= bus.csr_wdata[7];
               end
               ADDR_MIE:     mie_meie <= bus.csr_wdata[11];
               ADDR_MTVEC: begin
                  mtvec_base <= bus.csr_wdata[31:2];
`ifdef VECTORED_MTVEC_EN
                  mtvec_mode <= bus.csr_wdata[0];
`endif
               end
               ADDR_MEPC:    mepc   <= {bus.csr_wdata[31:2], 2'b00};
               ADDR_MCAUSE:  mcause <= bus.csr_wdata;
               default: ;
            endcase
         end
      end
   end

   // ------------------------------------------------------------------
   // Combinational CSR read; unmapped addresses read zero.
   // ------------------------------------------------------------------
   always_comb begin
      bus.csr_rdata = '0;
      case (bus.csr_addr)
         ADDR_MSTATUS: bus.csr_rdata = {24'd0, mstatus_mpie, 3'd0, mstatus_mie, 3'd0};
         ADDR_MIE:     bus.csr_rdata = {20'd0, mie_meie, 11'd0};
`ifdef VECTORED_MTVEC_EN
         ADDR_MTVEC:   bus.csr_rdata = {mtvec_base, 1'b0, mtvec_mode};
`else
         ADDR_MTVEC:   bus.csr_rdata = {mtvec_base, 2'b00};
`endif
         ADDR_MEPC:    bus.csr_rdata = mepc;
         ADDR_MCAUSE:  bus.csr_rdata = mcause;
         default:      bus.csr_rdata = '0;
      endcase
   end

   // exce is the REDIRECT state itself, so it is a registered one-cycle pulse.
   assign bus.exce    = (state == ST_REDIRECT);
   assign bus.busy    = (state != ST_IDLE);
   assign bus.exce_pc = exce_pc_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Purpose: self-checking bench for trap_ctrl: directed scenarios followed by a
//          randomized run against a behavioural model of the trap rules.
// Ports:   none; drives a trap_ctrl_if instance, clk and rstn.
`timescale 1ns/1ps
module tb_trap_ctrl;

   localparam logic [31:0] IRQC = 32'd11;
`ifdef VECTORED_MTVEC_EN
   localparam bit VEC = 1'b1;
`else
   localparam bit VEC = 1'b0;
`endif

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   int   checks = 0;
   int   errors = 0;

   trap_ctrl_if bus ();

   trap_ctrl #(
      .RESET_MTVEC (32'h0000_0100),
      .IRQ_CAUSE   (IRQC)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   bit          m_mie, m_mpie, m_meie, m_exce;
   logic [31:0] m_mtvec, m_mepc, m_mcause, m_pc_exp;
   int          m_blocked;

   task automatic model_reset();
      m_mie = 0; m_mpie = 0; m_meie = 0; m_exce = 0;
      m_mtvec = 32'h100; m_mepc = 0; m_mcause = 0; m_pc_exp = 0;
      m_blocked = 0;
   endtask

   function automatic logic [31:0] model_read(input logic [11:0] a);
      case (a)
         12'h300: return (m_mie ? 32'h8 : 32'h0) | (m_mpie ? 32'h80 : 32'h0);
         12'h304: return m_meie ? 32'h800 : 32'h0;
         12'h305: return m_mtvec;
         12'h341: return m_mepc;
         12'h342: return m_mcause;
         default: return 32'h0;
      endcase
   endfunction

   // Apply one clock edge's worth of architectural effect.
   task automatic model_step();
      bit          trap, ret, is_irq;
      logic [31:0] cause;
      trap = 0; ret = 0; is_irq = 0; cause = 0;
      m_exce = 0;
      if (m_blocked > 0) begin
         m_blocked--;
      end else begin
         if (bus.illegal_instr)    begin trap = 1; cause = 2;  end
         else if (bus.ebreak)      begin trap = 1; cause = 3;  end
         else if (bus.ecall)       begin trap = 1; cause = 11; end
         else if (bus.mret)        ret = 1;
         else if (bus.ext_irq && m_mie && m_meie) begin
            trap = 1; is_irq = 1; cause = 32'h8000_0000 | IRQC;
         end
         if (trap) begin
            m_pc_exp = (m_mtvec & ~32'h3) + ((is_irq && VEC && m_mtvec[0]) ? 4 * IRQC : 0);
            m_mepc = bus.pc; m_mcause = cause;
            m_mpie = m_mie;  m_mie = 0;
            m_blocked = 2;   m_exce = 1;
         end else if (ret) begin
            m_pc_exp = m_mepc;
            m_mie = m_mpie;  m_mpie = 1;
            m_blocked = 2;   m_exce = 1;
         end else if (bus.csr_we) begin
            case (bus.csr_addr)
               12'h300: begin m_mie = bus.csr_wdata[3]; m_mpie = bus.csr_wdata[7]; end
               12'h304: m_meie = bus.csr_wdata[11];
               12'h305: m_mtvec = VEC ? (bus.csr_wdata & ~32'h2) : (bus.csr_wdata & ~32'h3);
               12'h341: m_mepc = bus.csr_wdata & ~32'h3;
               12'h342: m_mcause = bus.csr_wdata;
               default: ;
            endcase
         end
      end
   endtask

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.pc = 0; bus.illegal_instr = 0; bus.ebreak = 0; bus.ecall = 0;
      bus.mret = 0; bus.ext_irq = 0; bus.csr_we = 0; bus.csr_addr = 0;
      bus.csr_wdata = 0;
   endtask

   task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
      bus.csr_addr = a;
      #1;
      chk(tag, bus.csr_rdata, exp);
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      bus.csr_we = 1; bus.csr_addr = a; bus.csr_wdata = d;
      tick();
      bus.csr_we = 0;
   endtask

   logic [11:0] addr_tab [0:6];

   initial begin
      addr_tab[0] = 12'h300; addr_tab[1] = 12'h304; addr_tab[2] = 12'h305;
      addr_tab[3] = 12'h341; addr_tab[4] = 12'h342; addr_tab[5] = 12'h343;
      addr_tab[6] = 12'h7C0;
      clear_inputs();

      // 1. reset values
      #12;
      chk1("rst_exce", bus.exce, 1'b0);
      chk1("rst_busy", bus.busy, 1'b0);
      chk("rst_exce_pc", bus.exce_pc, 32'h0);
      rd("rst_mtvec", 12'h305, 32'h100);
      rd("rst_mstatus", 12'h300, 32'h0);
      rstn = 1;
      tick();

      // 2. ecall redirect to mtvec base
      bus.pc = 32'h40; bus.ecall = 1;
      tick();
      bus.ecall = 0;
      chk1("ecall_exce", bus.exce, 1'b1);
      chk("ecall_pc", bus.exce_pc, 32'h100);
      chk1("ecall_busy1", bus.busy, 1'b1);
      rd("ecall_mepc", 12'h341, 32'h40);
      rd("ecall_mcause", 12'h342, 32'd11);
      rd("ecall_mstatus", 12'h300, 32'h0);
      tick();
      chk1("ecall_exce_off", bus.exce, 1'b0);
      chk1("ecall_busy2", bus.busy, 1'b1);
      tick();
      chk1("ecall_busy_end", bus.busy, 1'b0);

      // 3. external interrupt and mret
      wr(12'h300, 32'h8);
      wr(12'h304, 32'h800);
      rd("wr_mstatus", 12'h300, 32'h8);
      rd("wr_mie", 12'h304, 32'h800);
      bus.pc = 32'h80; bus.ext_irq = 1;
      tick();
      bus.ext_irq = 0;
      chk1("irq_exce", bus.exce, 1'b1);
      chk("irq_pc", bus.exce_pc, 32'h100);
      rd("irq_mcause", 12'h342, 32'h8000_000B);
      rd("irq_mepc", 12'h341, 32'h80);
      rd("irq_mstatus", 12'h300, 32'h80);
      tick(); tick();
      bus.mret = 1;
      tick();
      bus.mret = 0;
      chk1("mret_exce", bus.exce, 1'b1);
      chk("mret_pc", bus.exce_pc, 32'h80);
      rd("mret_mstatus", 12'h300, 32'h88);
      tick(); tick();

      // 4. priority and dropped CSR writes
      bus.illegal_instr = 1; bus.ecall = 1;
      bus.csr_we = 1; bus.csr_addr = 12'h305; bus.csr_wdata = 32'h200;
      tick();
      bus.illegal_instr = 0; bus.ecall = 0; bus.csr_we = 0;
      rd("prio_mcause", 12'h342, 32'd2);
      rd("prio_mtvec", 12'h305, 32'h100);
      tick();
      chk1("flush_busy", bus.busy, 1'b1);
      bus.csr_we = 1; bus.csr_addr = 12'h305; bus.csr_wdata = 32'h300;
      bus.ebreak = 1;
      tick();
      bus.csr_we = 0; bus.ebreak = 0;
      chk1("flush_evt_ignored", bus.exce, 1'b0);
      chk1("flush_done", bus.busy, 1'b0);
      rd("flush_mtvec", 12'h305, 32'h100);

      // 5. reset during REDIRECT
      bus.pc = 32'hC4; bus.ebreak = 1;
      tick();
      bus.ebreak = 0;
      chk1("pre_rst_exce", bus.exce, 1'b1);
      rstn = 0;
      #1;
      chk1("midrst_exce", bus.exce, 1'b0);
      chk1("midrst_busy", bus.busy, 1'b0);
      chk("midrst_exce_pc", bus.exce_pc, 32'h0);
      rd("midrst_mtvec", 12'h305, 32'h100);
      rd("midrst_mepc", 12'h341, 32'h0);
      rd("midrst_mcause", 12'h342, 32'h0);
      @(negedge clk);
      rd("midrst_mstatus", 12'h300, 32'h0);
      rd("midrst_mie", 12'h304, 32'h0);
      rstn = 1;
      tick();

      // 6. mtvec mode bit and held interrupt without re-entry
      wr(12'h305, 32'h201);
      wr(12'h300, 32'h8);
      wr(12'h304, 32'h800);
      rd("vec_mtvec", 12'h305, VEC ? 32'h201 : 32'h200);
      bus.pc = 32'h1000; bus.ext_irq = 1;
      tick();
      chk1("vec_exce", bus.exce, 1'b1);
      chk("vec_pc", bus.exce_pc, VEC ? 32'h22C : 32'h200);
      tick();
      chk1("hold_flush_exce", bus.exce, 1'b0);
      tick();
      chk1("hold_idle_exce", bus.exce, 1'b0);
      chk1("hold_idle_busy", bus.busy, 1'b0);
      tick();
      chk1("hold_no_reentry", bus.exce, 1'b0);
      bus.ext_irq = 0;
      tick();

      // 7. randomized run against the model
      rstn = 0;
      #2;
      rstn = 1;
      model_reset();
      tick();
      for (int i = 0; i < 400; i++) begin
         chk1("rnd_exce", bus.exce, m_exce);
         chk1("rnd_busy", bus.busy, (m_blocked > 0));
         if (m_exce) chk("rnd_exce_pc", bus.exce_pc, m_pc_exp);
         bus.pc            = $urandom & ~32'h3;
         bus.illegal_instr = ($urandom_range(0, 15) == 0);
         bus.ebreak        = ($urandom_range(0, 15) == 0);
         bus.ecall         = ($urandom_range(0, 15) == 0);
         bus.mret          = ($urandom_range(0, 11) == 0);
         bus.ext_irq       = ($urandom_range(0, 2) == 0);
         bus.csr_we        = ($urandom_range(0, 3) == 0);
         bus.csr_addr      = addr_tab[$urandom_range(0, 6)];
         bus.csr_wdata     = $urandom;
         #1;
         chk("rnd_rdata", bus.csr_rdata, model_read(bus.csr_addr));
         model_step();
         tick();
      end
      clear_inputs();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
